riscv_core_rf_wbarb: RTL

RISCV_CORE_RF_WBARB -- requirements
Module: riscv_core_rf_wbarb

---
 rtl/riscv_core_rf_wbarb.sv | 132 +++++++++++++
 1 files changed

// File: rtl/riscv_core_rf_wbarb.sv
// Register-file write-port arbiter: pipeline writeback has priority, mul/div results queue in a FIFO.
// Define RF_WBARB_STARVE_EN to enable the starvation counter that drives o_wa_hold.
module riscv_core_rf_wbarb #(
  parameter int DEPTH      = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        i_wa_clk,
  input  logic        i_wa_rst,
  input  logic        i_wa_wb_we,
  input  logic [4:0]  i_wa_wb_rd,
  input  logic [31:0] i_wa_wb_wd,
  input  logic        i_wa_md_valid,
  input  logic [4:0]  i_wa_md_rd,
  input  logic [31:0] i_wa_md_wd,
  output logic        o_wa_md_ready,
  input  logic        i_wa_md_issue,
  input  logic [4:0]  i_wa_md_issue_rd,
  input  logic [4:0]  i_wa_rs1,
  input  logic [4:0]  i_wa_rs2,
  output logic        o_wa_stall,
  output logic [31:0] o_wa_busy,
  output logic        o_wa_hold,
  output logic        o_wa_rf_we,
  output logic [4:0]  o_wa_rf_a3,
  output logic [31:0] o_wa_rf_wd
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic [4:0]    rd_mem_q [DEPTH];
  logic [31:0]   wd_mem_q [DEPTH];

  logic wb_valid, head_pending, head_we, enq;

  assign wb_valid      = i_wa_wb_we && (i_wa_wb_rd != 5'd0);
  assign head_pending  = (count_q != '0);
  // Head never writes in a reset cycle so a discarded entry cannot leak out.
  assign head_we       = head_pending && !wb_valid && !i_wa_rst;
  assign o_wa_md_ready = i_wa_rst || (count_q < FULL);
  assign enq           = i_wa_md_valid && o_wa_md_ready && (i_wa_md_rd != 5'd0);

  always_comb begin
    o_wa_rf_we = 1'b0;
    o_wa_rf_a3 = 5'd0;
    o_wa_rf_wd = 32'd0;
    if (wb_valid) begin
      o_wa_rf_we = 1'b1;
      o_wa_rf_a3 = i_wa_wb_rd;
      o_wa_rf_wd = i_wa_wb_wd;
    end else if (head_we) begin
      o_wa_rf_we = 1'b1;
      o_wa_rf_a3 = rd_mem_q[rd_ptr_q];
      o_wa_rf_wd = wd_mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    count_d = count_q;
    case ({enq, head_we})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Set after clear so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (head_we) busy_d[rd_mem_q[rd_ptr_q]] = 1'b0;
    if (i_wa_md_issue && (i_wa_md_issue_rd != 5'd0)) busy_d[i_wa_md_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_wa_clk) begin
    if (i_wa_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
      if (enq)     wr_ptr_q <= wr_ptr_q + 1'b1;
      if (head_we) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_wa_clk) begin
    if (enq) begin
      rd_mem_q[wr_ptr_q] <= i_wa_md_rd;
      wd_mem_q[wr_ptr_q] <= i_wa_md_wd;
    end
  end

  assign o_wa_busy  = busy_q;
  assign o_wa_stall = !i_wa_rst &&
                      (((i_wa_rs1 != 5'd0) && busy_q[i_wa_rs1]) ||
                       ((i_wa_rs2 != 5'd0) && busy_q[i_wa_rs2]));

`ifdef RF_WBARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [CW-1:0] starve_q, starve_d;
  logic          hold_q;

  always_comb begin
    starve_d = starve_q;
    if (!head_pending || head_we) starve_d = '0;
    else if (wb_valid && (starve_q != LIM)) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge i_wa_clk) begin
    if (i_wa_rst) begin
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      hold_q   <= (starve_d == LIM);
    end
  end

  assign o_wa_hold = hold_q;
`else
  assign o_wa_hold = 1'b0;
`endif

endmodule
